otter_mem_responder: RTL and testbench

//  Memory-side responder for the multicycle OTTER control FSM's strobes.

---
 rtl/otter_mem_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_otter_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : otter_mem_responder                                           |
// | Purpose  : Memory-side responder for the multicycle OTTER control FSM.   |
// |            Port 1 fetches instructions, port 2 performs sized data       |
// |            loads/stores. Both share one single-port word array; a        |
// |            fetch that collides with a data access is deferred by one     |
// |            cycle. Misaligned, illegal-size and out-of-range accesses are |
// |            suppressed and flagged with a one-cycle MEM_ERR pulse.        |
// | Ports    : CLK, RST_N (async, active low)                                |
// |            MEM_RDEN1/MEM_ADDR1 -> MEM_DOUT1       fetch port             |
// |            MEM_RDEN2/MEM_WE2/MEM_ADDR2/MEM_DIN2/MEM_SIZE/MEM_SIGN        |
// |              -> MEM_DOUT2                         data port              |
// |            MEM_ERR, MEM_BUSY                      status                 |
// |            IO_RD/IO_WR/IO_ADDR/IO_WDATA/IO_RDATA  MMIO side-port         |
// | Config   : `define OTTER_MMIO_EN routes port-2 accesses at or above      |
// |            IO_BASE to the IO_* side-port. Undefined: IO_* tied low and   |
// |            such addresses are out-of-range.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module otter_mem_responder #(
   parameter int          DEPTH   = 16384,
   parameter logic [31:0] IO_BASE = 32'h1100_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        MEM_RDEN1,
   input  logic [31:0] MEM_ADDR1,
   output logic [31:0] MEM_DOUT1,
   input  logic        MEM_RDEN2,
   input  logic        MEM_WE2,
   input  logic [31:0] MEM_ADDR2,
   input  logic [31:0] MEM_DIN2,
   input  logic [1:0]  MEM_SIZE,
   input  logic        MEM_SIGN,
   output logic [31:0] MEM_DOUT2,
   output logic        MEM_ERR,
   output logic        MEM_BUSY,
   output logic        IO_RD,
   output logic        IO_WR,
   output logic [31:0] IO_ADDR,
   output logic [31:0] IO_WDATA,
   input  logic [31:0] IO_RDATA
);

   localparam int c_AW = $clog2(DEPTH);

   localparam logic [0:0] c_ST_IDLE  = 1'b0;
   localparam logic [0:0] c_ST_DEFER = 1'b1;

   // Lane select followed by sign/zero extension. The half lane is always
   // {A1,0}, so a byte shift of the lane index covers bytes and halves.
   function automatic logic [31:0] f_load(input logic [31:0] word,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane,
                                          input logic        sign);
      logic [31:0] v_sh;
      v_sh = word >> {lane, 3'b000};
      case (size)
         2'b00:   f_load = {{24{sign & v_sh[7]}},  v_sh[7:0]};
         2'b01:   f_load = {{16{sign & v_sh[15]}}, v_sh[15:0]};
         default: f_load = word;
      endcase
   endfunction

   logic [31:0]     r_mem [0:DEPTH-1];
   logic [0:0]      r_state;
   logic [31:0]     r_addr1;
   logic [31:0]     r_dout1;
   logic [31:0]     r_dout2;
   logic            r_err;

   logic            w_idle;
   logic            w_p2_req;
   logic            w_p2_go;
   logic            w_p1_go;
   logic            w_defer_go;
   logic [31:0]     w_p1_addr;
   logic            w_p1_bad;
   logic            w_p2_range;
   logic            w_p2_oor;
   logic            w_p2_bad;
   logic [c_AW-1:0] w_idx1;
   logic [c_AW-1:0] w_idx2;
   logic [3:0]      w_be;
   logic [31:0]     w_wdata;
   logic            w_mem_we;

   // ---------------------------------------------------------------------
   // Request arbitration: port 2 always wins in IDLE; a colliding fetch is
   // parked in r_addr1 and served from DEFER, where new strobes are ignored.
   // ---------------------------------------------------------------------
   assign w_idle     = (r_state == c_ST_IDLE);
   assign w_p2_req   = MEM_RDEN2 | MEM_WE2;
   assign w_p2_go    = w_idle & w_p2_req;
   assign w_defer_go = w_idle & w_p2_req & MEM_RDEN1;
   assign w_p1_go    = (w_idle & MEM_RDEN1 & ~w_p2_req) | ~w_idle;
   assign w_p1_addr  = w_idle ? MEM_ADDR1 : r_addr1;

   // Any address bit above the array span makes the access out-of-range;
   // addresses never alias back into the array.
   assign w_p1_bad   = (|w_p1_addr[1:0]) | (|w_p1_addr[31:c_AW+2]);
   assign w_p2_range = |MEM_ADDR2[31:c_AW+2];
   assign w_idx1     = w_p1_addr[c_AW+1:2];
   assign w_idx2     = MEM_ADDR2[c_AW+1:2];

`ifdef OTTER_MMIO_EN
   logic        w_is_io;
   logic        r_io_rd;
   logic        r_io_wr;
   logic [31:0] r_io_addr;
   logic [31:0] r_io_wdata;
   logic [1:0]  r_io_size;
   logic [1:0]  r_io_lane;
   logic        r_io_sign;

   assign w_is_io  = (MEM_ADDR2 >= IO_BASE);
   assign w_p2_oor = w_p2_range & ~w_is_io;
   assign w_mem_we = w_p2_go & ~w_p2_bad & MEM_WE2 & ~w_is_io;
   assign IO_RD    = r_io_rd;
   assign IO_WR    = r_io_wr;
   assign IO_ADDR  = r_io_addr;
   assign IO_WDATA = r_io_wdata;
`else
   logic w_unused_io;

   assign w_p2_oor    = w_p2_range;
   assign w_mem_we    = w_p2_go & ~w_p2_bad & MEM_WE2;
   assign IO_RD       = 1'b0;
   assign IO_WR       = 1'b0;
   assign IO_ADDR     = 32'd0;
   assign IO_WDATA    = 32'd0;
   assign w_unused_io = ^{IO_RDATA, IO_BASE};
`endif

   // Port-2 legality: alignment follows the access size, size 11 is illegal.
   always_comb begin
      w_p2_bad = 1'b0;
      case (MEM_SIZE)
         2'b00:   w_p2_bad = 1'b0;
         2'b01:   w_p2_bad = MEM_ADDR2[0];
         2'b10:   w_p2_bad = |MEM_ADDR2[1:0];
         default: w_p2_bad = 1'b1;
      endcase
      if (w_p2_oor) begin
         w_p2_bad = 1'b1;
      end
   end

   // Store lane steering: data arrives LSB-aligned and is shifted into the
   // lane(s) selected by ADDR2[1:0].
   always_comb begin
      w_wdata = MEM_DIN2 << {MEM_ADDR2[1:0], 3'b000};
      case (MEM_SIZE)
         2'b00:   w_be = 4'b0001 << MEM_ADDR2[1:0];
         2'b01:   w_be = 4'b0011 << MEM_ADDR2[1:0];
         default: w_be = 4'b1111;
      endcase
   end

   // Array contents are deliberately not reset.
   always_ff @(posedge CLK) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx2][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= c_ST_IDLE;
         r_addr1    <= 32'd0;
         r_dout1    <= 32'd0;
         r_dout2    <= 32'd0;
         r_err      <= 1'b0;
`ifdef OTTER_MMIO_EN
         r_io_rd    <= 1'b0;
         r_io_wr    <= 1'b0;
         r_io_addr  <= 32'd0;
         r_io_wdata <= 32'd0;
         r_io_size  <= 2'd0;
         r_io_lane  <= 2'd0;
         r_io_sign  <= 1'b0;
`endif
      end else begin
         r_state <= w_defer_go ? c_ST_DEFER : c_ST_IDLE;
         r_err   <= 1'b0;

         if (w_defer_go) begin
            r_addr1 <= MEM_ADDR1;
         end

`ifdef OTTER_MMIO_EN
         r_io_rd    <= 1'b0;
         r_io_wr    <= 1'b0;
         r_io_addr  <= 32'd0;
         r_io_wdata <= 32'd0;
         // MMIO read data is taken in the IO_RD cycle; a new port-2 access
         // launched in that same cycle takes precedence below.
         if (r_io_rd) begin
            r_dout2 <= f_load(IO_RDATA, r_io_size, r_io_lane, r_io_sign);
         end
`endif

         if (w_p2_go) begin
            if (w_p2_bad) begin
               r_dout2 <= 32'd0;
               r_err   <= 1'b1;
            end else begin
               // Read+write together: the write goes ahead, DOUT2 holds.
               r_err <= MEM_RDEN2 & MEM_WE2;
`ifdef OTTER_MMIO_EN
               if (w_is_io) begin
                  r_io_addr <= MEM_ADDR2;
                  if (MEM_WE2) begin
                     r_io_wr    <= 1'b1;
                     r_io_wdata <= MEM_DIN2;
                  end else begin
                     r_io_rd   <= 1'b1;
                     r_io_size <= MEM_SIZE;
                     r_io_lane <= MEM_ADDR2[1:0];
                     r_io_sign <= MEM_SIGN;
                  end
               end else if (!MEM_WE2) begin
                  r_dout2 <= f_load(r_mem[w_idx2], MEM_SIZE, MEM_ADDR2[1:0], MEM_SIGN);
               end
`else
               if (!MEM_WE2) begin
                  r_dout2 <= f_load(r_mem[w_idx2], MEM_SIZE, MEM_ADDR2[1:0], MEM_SIGN);
               end
`endif
            end
         end

         if (w_p1_go) begin
            if (w_p1_bad) begin
               r_dout1 <= 32'd0;
               r_err   <= 1'b1;
            end else begin
               r_dout1 <= r_mem[w_idx1];
            end
         end
      end
   end

   assign MEM_DOUT1 = r_dout1;
   assign MEM_DOUT2 = r_dout2;
   assign MEM_ERR   = r_err;
   assign MEM_BUSY  = (r_state == c_ST_DEFER);

endmodule
`default_nettype wire

// File: tb/tb_otter_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_otter_mem_responder                                        |
// | Purpose  : Self-checking bench for otter_mem_responder (default build).  |
// |            A byte-addressed reference memory predicts every fetch, load, |
// |            error pulse and busy flag.                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_otter_mem_responder;

   localparam int c_DEPTH = 256;
   localparam int c_BYTES = 4 * c_DEPTH;

   logic        CLK       = 1'b0;
   logic        RST_N     = 1'b1;
   logic        MEM_RDEN1 = 1'b0;
   logic [31:0] MEM_ADDR1 = 32'd0;
   logic        MEM_RDEN2 = 1'b0;
   logic        MEM_WE2   = 1'b0;
   logic [31:0] MEM_ADDR2 = 32'd0;
   logic [31:0] MEM_DIN2  = 32'd0;
   logic [1:0]  MEM_SIZE  = 2'd0;
   logic        MEM_SIGN  = 1'b0;
   logic [31:0] IO_RDATA  = 32'd0;
   logic [31:0] MEM_DOUT1;
   logic [31:0] MEM_DOUT2;
   logic        MEM_ERR;
   logic        MEM_BUSY;
   logic        IO_RD;
   logic        IO_WR;
   logic [31:0] IO_ADDR;
   logic [31:0] IO_WDATA;

   otter_mem_responder #(
      .DEPTH   (c_DEPTH),
      .IO_BASE (32'h1100_0000)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .MEM_RDEN1 (MEM_RDEN1),
      .MEM_ADDR1 (MEM_ADDR1),
      .MEM_DOUT1 (MEM_DOUT1),
      .MEM_RDEN2 (MEM_RDEN2),
      .MEM_WE2   (MEM_WE2),
      .MEM_ADDR2 (MEM_ADDR2),
      .MEM_DIN2  (MEM_DIN2),
      .MEM_SIZE  (MEM_SIZE),
      .MEM_SIGN  (MEM_SIGN),
      .MEM_DOUT2 (MEM_DOUT2),
      .MEM_ERR   (MEM_ERR),
      .MEM_BUSY  (MEM_BUSY),
      .IO_RD     (IO_RD),
      .IO_WR     (IO_WR),
      .IO_ADDR   (IO_ADDR),
      .IO_WDATA  (IO_WDATA),
      .IO_RDATA  (IO_RDATA)
   );

   always #5 CLK = ~CLK;

   // Reference model state
   logic [7:0]  m [0:c_BYTES-1];
   logic [31:0] exp_d1 = 32'd0;
   logic [31:0] exp_d2 = 32'd0;
   logic        exp_err = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic bad2(input logic [31:0] a, input logic [1:0] sz);
      int unsigned n;
      if (sz == 2'd3) return 1'b1;
      n = 32'd1 << sz;
      if ((a % n) != 0) return 1'b1;
      return (a >= c_BYTES);
   endfunction

   function automatic logic bad1(input logic [31:0] a);
      return ((a % 4) != 0) || (a >= c_BYTES);
   endfunction

   // Little-endian load of 1/2/4 bytes with arithmetic sign extension.
   function automatic logic [31:0] ld(input logic [31:0] a, input logic [1:0] sz, input logic sg);
      int     n;
      longint v;
      n = 1 << sz;
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(m[a + i]) << (8 * i);
      if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      return v[31:0];
   endfunction

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      int n;
      n = 1 << sz;
      for (int i = 0; i < n; i++) m[a + i] = 8'(d >> (8 * i));
   endtask

   task automatic idle();
      MEM_RDEN1 = 1'b0;
      MEM_RDEN2 = 1'b0;
      MEM_WE2   = 1'b0;
   endtask

   task automatic predict_p1(input logic [31:0] a);
      if (bad1(a)) begin
         exp_d1  = 32'd0;
         exp_err = 1'b1;
      end else begin
         exp_d1  = ld(a, 2'd2, 1'b0);
         exp_err = 1'b0;
      end
   endtask

   // One transaction: drive, predict, clock, compare. A collision takes a
   // second cycle, during which random strobes are driven and must be ignored.
   task automatic step(input logic r1, input logic [31:0] a1,
                       input logic r2, input logic w2, input logic [31:0] a2,
                       input logic [31:0] d, input logic [1:0] sz, input logic sg);
      logic coll;
      coll      = r1 & (r2 | w2);
      MEM_RDEN1 = r1;
      MEM_ADDR1 = a1;
      MEM_RDEN2 = r2;
      MEM_WE2   = w2;
      MEM_ADDR2 = a2;
      MEM_DIN2  = d;
      MEM_SIZE  = sz;
      MEM_SIGN  = sg;
      exp_err   = 1'b0;
      if (r2 | w2) begin
         if (bad2(a2, sz)) begin
            exp_d2  = 32'd0;
            exp_err = 1'b1;
         end else begin
            if (r2 && !w2) exp_d2 = ld(a2, sz, sg);
            if (w2) wr(a2, d, sz);
            exp_err = r2 & w2;
         end
      end else if (r1) begin
         predict_p1(a1);
      end
      @(posedge CLK); #1;
      if (coll) begin
         MEM_RDEN1 = 1'($urandom_range(0, 1));
         MEM_ADDR1 = $urandom_range(0, c_DEPTH - 1) << 2;
         MEM_RDEN2 = 1'($urandom_range(0, 1));
         MEM_WE2   = 1'($urandom_range(0, 1));
         MEM_ADDR2 = $urandom_range(0, c_DEPTH - 1) << 2;
         MEM_DIN2  = $urandom;
         MEM_SIZE  = 2'd2;
      end else begin
         idle();
      end
      chk("err", MEM_ERR, exp_err);
      chk("dout1", MEM_DOUT1, exp_d1);
      chk("dout2", MEM_DOUT2, exp_d2);
      chk("busy", MEM_BUSY, coll);
      chk("io_quiet", {IO_RD, IO_WR, |IO_ADDR, |IO_WDATA}, 32'd0);
      if (coll) begin
         predict_p1(a1);
         @(posedge CLK); #1;
         idle();
         chk("defer_err", MEM_ERR, exp_err);
         chk("defer_dout1", MEM_DOUT1, exp_d1);
         chk("defer_dout2", MEM_DOUT2, exp_d2);
         chk("defer_busy", MEM_BUSY, 1'b0);
      end
   endtask

   initial begin
      int unsigned kind;
      int unsigned r;
      logic [1:0]  sz;
      logic [31:0] a1;
      logic [31:0] a2;

      // Reset
      #2 RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_dout1", MEM_DOUT1, 32'd0);
      chk("rst_dout2", MEM_DOUT2, 32'd0);
      chk("rst_err", MEM_ERR, 32'd0);
      chk("rst_busy", MEM_BUSY, 32'd0);
      chk("rst_io", {IO_RD, IO_WR, |IO_ADDR, |IO_WDATA}, 32'd0);
      RST_N = 1'b1;

      // Fill the whole array so every later read is predictable
      for (int w = 0; w < c_DEPTH; w++) step(0, 0, 0, 1, w << 2, $urandom, 2'd2, 0);
      step(0, 0, 0, 1, 32'h8, 32'h1234_5678, 2'd2, 0);

      // Word store then fetch
      step(0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 2'd2, 0);
      step(1, 32'h100, 0, 0, 0, 0, 2'd0, 0);
      chk("fetch_deadbeef", MEM_DOUT1, 32'hDEAD_BEEF);
      chk("fetch_deadbeef_err", MEM_ERR, 32'd0);

      // Byte store, signed and unsigned byte loads
      step(0, 0, 0, 1, 32'h103, 32'h80, 2'd0, 0);
      step(0, 0, 1, 0, 32'h103, 0, 2'd0, 1);
      chk("lb_signed", MEM_DOUT2, 32'hFFFF_FF80);
      step(0, 0, 1, 0, 32'h103, 0, 2'd0, 0);
      chk("lb_unsigned", MEM_DOUT2, 32'h0000_0080);

      // Misaligned half load: error pulse, data zeroed, memory intact
      step(0, 0, 1, 0, 32'h101, 0, 2'd1, 0);
      chk("lh_mis_err", MEM_ERR, 32'd1);
      chk("lh_mis_dout2", MEM_DOUT2, 32'd0);
      step(0, 0, 0, 0, 0, 0, 2'd0, 0);
      chk("err_one_cycle", MEM_ERR, 32'd0);
      step(0, 0, 1, 0, 32'h100, 0, 2'd2, 0);
      chk("mem_unchanged", MEM_DOUT2, 32'h80AD_BEEF);

      // Colliding fetch and load
      step(1, 32'h0, 1, 0, 32'h4, 0, 2'd2, 0);

      // Reset while a deferred fetch is pending
      step(1, 32'h100, 0, 0, 0, 0, 2'd0, 0);
      MEM_RDEN1 = 1'b1;
      MEM_ADDR1 = 32'h8;
      MEM_RDEN2 = 1'b1;
      MEM_WE2   = 1'b0;
      MEM_ADDR2 = 32'hC;
      MEM_SIZE  = 2'd2;
      MEM_SIGN  = 1'b0;
      @(posedge CLK); #1;
      idle();
      chk("rstdef_busy", MEM_BUSY, 32'd1);
      chk("rstdef_dout2", MEM_DOUT2, ld(32'hC, 2'd2, 1'b0));
      chk("rstdef_dout1_old", MEM_DOUT1, 32'h80AD_BEEF);
      #2 RST_N = 1'b0;
      #1;
      chk("rstdef_dout1_async", MEM_DOUT1, 32'd0);
      chk("rstdef_dout2_async", MEM_DOUT2, 32'd0);
      chk("rstdef_busy_async", MEM_BUSY, 32'd0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("rstdef_no_fetch", MEM_DOUT1, 32'd0);
      chk("rstdef_busy_after", MEM_BUSY, 32'd0);
      chk("rstdef_err_after", MEM_ERR, 32'd0);
      exp_d1 = 32'd0;
      exp_d2 = 32'd0;

      // MMIO address in the default build is out-of-range
      step(0, 0, 0, 1, 32'h1100_0000, 32'h55, 2'd0, 0);
      chk("mmio_store_err", MEM_ERR, 32'd1);
      chk("mmio_store_iowr", IO_WR, 32'd0);

      // Boundaries
      step(0, 0, 1, 0, c_BYTES - 4, 0, 2'd2, 0);
      step(0, 0, 1, 0, c_BYTES, 0, 2'd2, 0);
      chk("oor_word_err", MEM_ERR, 32'd1);
      step(1, c_BYTES, 0, 0, 0, 0, 2'd0, 0);
      chk("oor_fetch_dout1", MEM_DOUT1, 32'd0);
      step(1, 32'h2, 0, 0, 0, 0, 2'd0, 0);
      step(0, 0, 1, 0, 32'h10, 0, 2'd3, 0);
      step(0, 0, 1, 1, 32'h200, 32'hCAFE_F00D, 2'd2, 0);
      chk("rdwe_err", MEM_ERR, 32'd1);
      step(0, 0, 1, 0, 32'h200, 0, 2'd2, 0);
      chk("rdwe_wrote", MEM_DOUT2, 32'hCAFE_F00D);
      step(0, 0, 1, 0, 32'h202, 0, 2'd1, 1);
      step(0, 0, 1, 0, 32'h3FF, 0, 2'd0, 1);

      // Randomised mix
      for (int it = 0; it < 400; it++) begin
         kind = $urandom_range(0, 5);
         sz   = 2'($urandom_range(0, 3));
         r    = $urandom_range(0, 9);
         a2   = $urandom_range(0, c_BYTES - 1);
         if (r == 0) a2 = c_BYTES + $urandom_range(0, 1023);
         else if (r >= 2 && sz != 2'd3) a2 = a2 - (a2 % (32'd1 << sz));
         r  = $urandom_range(0, 9);
         a1 = $urandom_range(0, c_DEPTH - 1) << 2;
         if (r == 0) a1 = a1 + $urandom_range(1, 3);
         else if (r == 1) a1 = c_BYTES + ($urandom_range(0, 255) << 2);
         case (kind)
            0: step(0, 0, 1, 0, a2, 0, sz, 1'($urandom_range(0, 1)));
            1: step(0, 0, 0, 1, a2, $urandom, sz, 0);
            2: step(0, 0, 1, 1, a2, $urandom, sz, 0);
            3: step(1, a1, 0, 0, 0, 0, 2'd0, 0);
            4: step(1, a1, 1, 0, a2, 0, sz, 1'($urandom_range(0, 1)));
            default: step(1, a1, 0, 1, a2, $urandom, sz, 0);
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
